// File: rtl/divf_iter.sv
`default_nettype none
// ============================================================================
// Module   : divf_iter
// Purpose  : Sequential IEEE-754 single-precision divider, restoring mantissa
//            division at one quotient bit per clock, fixed 26-clock latency.
// Revision : 1.0 - initial release
// ============================================================================
module divf_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] s,
  output logic        dz,
  output logic        ovf,
  output logic        unf,
  output logic        inv
);

  localparam int QBITS = 25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_NORM = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;
  logic              w_accept;

  logic              r_sign;
  logic [7:0]        r_ea, r_eb;
  logic [23:0]       r_mb;
  logic [25:0]       r_rem;
  logic [QBITS-1:0]  r_q;
  logic [4:0]        r_cnt;
  logic              r_inv_op, r_az, r_bz;

  logic              r_done;
  logic [31:0]       r_s;
  logic              r_dz, r_ovf, r_unf, r_inv;

  logic              w_ge;
  logic [25:0]       w_diff, w_rem_nxt;
  logic signed [9:0] w_e, w_exp;
  logic [22:0]       w_frac;
  logic [31:0]       w_s;
  logic              w_dz, w_ovf, w_unf, w_inv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        w_accept    = 1'b1;
        w_state_nxt = ST_DIV;
      end
      ST_DIV:  if (r_cnt == 5'd0) w_state_nxt = ST_NORM;
      ST_NORM: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Restoring step: remainder always stays below 2*mb, so 26 bits never overflow.
  always_comb begin
    w_ge      = (r_rem >= {2'b00, r_mb});
    w_diff    = r_rem - {2'b00, r_mb};
    w_rem_nxt = w_ge ? (w_diff << 1) : (r_rem << 1);
  end

  always_comb begin
    w_e    = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb}) + 10'sd127;
    w_exp  = r_q[QBITS-1] ? w_e : (w_e - 10'sd1);
    w_frac = r_q[QBITS-1] ? r_q[23:1] : r_q[22:0];
    w_s    = {r_sign, w_exp[7:0], w_frac};
    w_dz   = 1'b0;
    w_ovf  = 1'b0;
    w_unf  = 1'b0;
    w_inv  = 1'b0;
    if (r_inv_op) begin
      w_s   = 32'h7FC0_0000;
      w_inv = 1'b1;
    end else if (r_az) begin
      w_s = {r_sign, 31'b0};
    end else if (r_bz) begin
      w_s  = {r_sign, 8'hFF, 23'b0};
      w_dz = 1'b1;
    end else if (w_exp >= 10'sd255) begin
      w_s   = {r_sign, 8'hFF, 23'b0};
      w_ovf = 1'b1;
    end else if (w_exp <= 10'sd0) begin
      w_s   = {r_sign, 31'b0};
      w_unf = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign   <= 1'b0;
      r_ea     <= '0;
      r_eb     <= '0;
      r_mb     <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_inv_op <= 1'b0;
      r_az     <= 1'b0;
      r_bz     <= 1'b0;
      r_done   <= 1'b0;
      r_s      <= '0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_inv    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_sign   <= a[31] ^ b[31];
        r_ea     <= a[30:23];
        r_eb     <= b[30:23];
        r_rem    <= {2'b01, a[22:0]};
        r_mb     <= {1'b1, b[22:0]};
        r_q      <= '0;
        r_cnt    <= 5'd24;
        // Denormals are flushed: exponent field 0 counts as zero.
        r_inv_op <= (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) ||
                    ((a[30:23] == 8'h00) && (b[30:23] == 8'h00));
        r_az     <= (a[30:23] == 8'h00);
        r_bz     <= (b[30:23] == 8'h00);
      end else if (r_state == ST_DIV) begin
        r_q   <= {r_q[QBITS-2:0], w_ge};
        r_rem <= w_rem_nxt;
        r_cnt <= r_cnt - 5'd1;
      end else if (r_state == ST_NORM) begin
        r_done <= 1'b1;
        r_s    <= w_s;
        r_dz   <= w_dz;
        r_ovf  <= w_ovf;
        r_unf  <= w_unf;
        r_inv  <= w_inv;
      end
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign s    = r_s;
  assign dz   = r_dz;
  assign ovf  = r_ovf;
  assign unf  = r_unf;
  assign inv  = r_inv;

endmodule
`default_nettype wire

// File: tb/tb_divf_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_divf_iter
// Purpose  : Self-checking bench for divf_iter: vector table, corner sequences
//            and random operands against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divf_iter;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a, b, s;
  logic        busy, done, dz, ovf, unf, inv;

  int n_tests = 0;
  int n_fail  = 0;

  divf_iter dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .s(s),
    .dz(dz), .ovf(ovf), .unf(unf), .inv(inv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic [3:0]  fl;   // {dz, ovf, unf, inv}
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Quotient taken as floor(ma * 2^24 / mb) with plain integer division.
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
    logic [35:0]     r;
    logic            sg;
    int              ex, ey, e;
    longint unsigned mx, my, q;
    logic [22:0]     fr;
    logic [7:0]      e8;
    sg = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = 64'h80_0000 + longint'(x[22:0]);
    my = 64'h80_0000 + longint'(y[22:0]);
    q  = (mx << 24) / my;
    if (q >= 64'd16777216) begin
      fr = q[23:1];
      e  = ex - ey + 127;
    end else begin
      fr = q[22:0];
      e  = ex - ey + 126;
    end
    e8 = e[7:0];
    if (ex == 255 || ey == 255 || (ex == 0 && ey == 0)) r = {4'b0001, 32'h7FC0_0000};
    else if (ex == 0)                                   r = {4'b0000, sg, 31'b0};
    else if (ey == 0)                                   r = {4'b1000, sg, 8'hFF, 23'b0};
    else if (e >= 255)                                  r = {4'b0100, sg, 8'hFF, 23'b0};
    else if (e <= 0)                                    r = {4'b0010, sg, 31'b0};
    else                                                r = {4'b0000, sg, e8, fr};
    return r;
  endfunction

  task automatic wait_done(inout int lat);
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Called 1 time unit after a rising edge; returns edges from accept to done.
  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb,
                        output int lat, output logic busy1, output logic done1);
    a = xa; b = xb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy1 = busy;
    done1 = done;
    lat   = 0;
    wait_done(lat);
  endtask

  function automatic logic [31:0] rnd_op();
    logic [7:0] ex;
    int         sel;
    sel = $urandom_range(0, 15);
    case (sel)
      0:       ex = 8'h00;
      1:       ex = 8'hFF;
      2:       ex = 8'($urandom_range(0, 255));
      3:       ex = 8'($urandom_range(200, 254));
      4:       ex = 8'($urandom_range(1, 40));
      default: ex = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
  endfunction

  initial begin
    vec_t        vecs [10];
    int          lat;
    logic        busy1, done1, saw;
    logic [31:0] ra, rb;

    vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000};
    vecs[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000};
    vecs[2] = '{32'hBF800000, 32'h00000000, 32'hFF800000, 4'b1000};
    vecs[3] = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001};
    vecs[4] = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0100};
    vecs[5] = '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0010};
    vecs[6] = '{32'h7F800000, 32'h3F800000, 32'h7FC00000, 4'b0001};
    vecs[7] = '{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000};
    vecs[8] = '{32'hBF800000, 32'h40400000, 32'hBEAAAAAA, 4'b0000};
    vecs[9] = '{32'h40000000, 32'h3F800000, 32'h40000000, 4'b0000};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({busy, done, dz, ovf, unf, inv, s}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat, busy1, done1);
      check($sformatf("vec%0d_busy_after_accept", i), 64'(busy1), 64'd1);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd26);
      check($sformatf("vec%0d_busy_at_done", i), 64'(busy), 64'd0);
      check($sformatf("vec%0d_result", i), 64'({dz, ovf, unf, inv, s}), 64'({vecs[i].fl, vecs[i].s}));
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
    end

    // start while busy must be ignored
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 0;
    repeat (9) begin @(posedge clk); #1; lat++; end
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    lat++; start = 1'b0;
    wait_done(lat);
    check("ignore_start_latency", 64'(lat), 64'd26);
    check("ignore_start_result", 64'({dz, ovf, unf, inv, s}), 64'({4'b0000, 32'h40400000}));
    @(posedge clk); #1;

    // flags and s persist across a new start until rewritten
    run_op(32'h40000000, 32'h00000000, lat, busy1, done1);
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 0;
    repeat (5) begin @(posedge clk); #1; lat++; end
    check("flags_held_during_op", 64'({dz, s}), 64'({1'b1, 32'h7F800000}));
    wait_done(lat);
    check("flags_rewritten", 64'({dz, ovf, unf, inv, s}), 64'({4'b0000, 32'h3EAAAAAA}));

    // back-to-back: accept on the done edge, 27 cycles per result
    run_op(32'h40C00000, 32'h40000000, lat, busy1, done1);
    check("b2b_done_dropped", 64'({busy1, done1}), 64'b10);
    check("b2b_latency", 64'(lat), 64'd26);
    check("b2b_result", 64'(s), 64'h40400000);
    @(posedge clk); #1;

    // reset mid-division
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midreset_outputs", 64'({busy, done, dz, ovf, unf, inv, s}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    saw = 1'b0;
    repeat (30) begin @(posedge clk); #1; if (done) saw = 1'b1; end
    check("midreset_no_done", 64'(saw), 64'd0);
    run_op(32'h7F000000, 32'h3E800000, lat, busy1, done1);
    check("after_reset_latency", 64'(lat), 64'd26);
    check("after_reset_result", 64'({dz, ovf, unf, inv, s}), 64'({4'b0100, 32'h7F800000}));
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) begin
      ra = rnd_op();
      rb = rnd_op();
      run_op(ra, rb, lat, busy1, done1);
      check($sformatf("rnd%0d_latency", i), 64'(lat), 64'd26);
      check($sformatf("rnd%0d_%h_div_%h", i, ra, rb), 64'({dz, ovf, unf, inv, s}), 64'(model(ra, rb)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
